// File: rtl/sum_n_ctrl.sv
// Sequencer for the "sum of N numbers" datapath: accepts N, then N operands over valid/ready.
// Define SUM_N_OVF_DETECT_EN to build the sticky carry-out overflow flag; otherwise ovf is tied low.
module sum_n_ctrl #(
  parameter int DATA_W = 4,
  parameter int SUM_W  = 7,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  n_reg_q, n_reg_d;
  logic              din_ready_q, din_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;

`ifdef SUM_N_OVF_DETECT_EN
  logic              ovf_q, ovf_d;

  // Widened add so the carry out of the accumulator MSB is visible.
  function automatic logic [SUM_W:0] add_carry(input logic [SUM_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + {{(SUM_W+1-DATA_W){1'b0}}, b};
  endfunction
`else
  function automatic logic [SUM_W-1:0] add_wrap(input logic [SUM_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + {{(SUM_W-DATA_W){1'b0}}, b};
  endfunction
`endif

  assign xfer = din_valid && din_ready_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    n_reg_d = n_reg_q;
`ifdef SUM_N_OVF_DETECT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d = '0;
`ifdef SUM_N_OVF_DETECT_EN
          ovf_d = 1'b0;
`endif
          if (n != '0) begin
            n_reg_d = n;
            count_d = '0;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
`ifdef SUM_N_OVF_DETECT_EN
          {ovf_d, sum_d} = add_carry(sum_q, din);
          ovf_d = ovf_d | ovf_q;
`else
          sum_d = add_wrap(sum_q, din);
`endif
          count_d = count_q + CNT_W'(1);
          if (count_q == n_reg_q - CNT_W'(1))
            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they appear registered with it.
    din_ready_d = (state_d == ACCUM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      n_reg_q     <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SUM_N_OVF_DETECT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      n_reg_q     <= n_reg_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SUM_N_OVF_DETECT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
`ifdef SUM_N_OVF_DETECT_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_sum_n_ctrl.sv
// Directed bench for sum_n_ctrl: expected {ovf,sum} pushed per run, popped when done pulses.
module tb_sum_n_ctrl;
  localparam int DATA_W = 4;
  localparam int SUM_W  = 7;
  localparam int CNT_W  = 4;
`ifdef SUM_N_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  n;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  logic [SUM_W:0]    sb[$];
  logic [DATA_W-1:0] ops[16];

  sum_n_ctrl #(.DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .busy(busy),
    .done(done), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1ns after the edge; any done pulse is scored here.
  task automatic tick();
    logic [SUM_W:0] e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sb_result", 32'({ovf, sum}), 32'(e));
      end
    end
  endtask

  task automatic run(input int nn, input int gap, input int ign_at);
    int acc;
    bit o;
    logic [SUM_W:0] e;
    acc = 0;
    o = 1'b0;
    for (int i = 0; i < nn; i++) begin
      acc += int'(ops[i]);
      if (acc >= 128) begin
        acc -= 128;
        o = 1'b1;
      end
    end
    e = {o & OVF_EN, 7'(acc)};
    sb.push_back(e);
    start = 1'b1;
    n = CNT_W'(nn);
    tick();
    start = 1'b0;
    n = CNT_W'($urandom);
    if (nn == 0) begin
      check("n0_done", 32'(done), 32'(1));
      check("n0_ready", 32'(din_ready), 32'(0));
      check("n0_sum", 32'(sum), 32'(0));
      tick();
      check("n0_idle_busy", 32'(busy), 32'(0));
      check("n0_ready2", 32'(din_ready), 32'(0));
      return;
    end
    check("accum_busy", 32'(busy), 32'(1));
    check("accum_ready", 32'(din_ready), 32'(1));
    for (int i = 0; i < nn; i++) begin
      din_valid = 1'b1;
      din = ops[i];
      if (i == ign_at) begin
        start = 1'b1;
        n = CNT_W'(1);
      end
      tick();
      start = 1'b0;
      din_valid = 1'b0;
      din = DATA_W'($urandom);
      if (i < nn - 1) begin
        check("no_early_done", 32'(done), 32'(0));
        for (int g = 0; g < gap; g++) begin
          tick();
          check("gap_hold_ready", 32'(din_ready), 32'(1));
        end
      end else begin
        check("done_latency", 32'(done), 32'(1));
        check("done_busy", 32'(busy), 32'(1));
        check("done_ready", 32'(din_ready), 32'(0));
      end
    end
    tick();
    check("post_done_low", 32'(done), 32'(0));
    check("post_busy_low", 32'(busy), 32'(0));
    check("post_sum_hold", 32'(sum), 32'(e[SUM_W-1:0]));
    check("post_ovf_hold", 32'(ovf), 32'(e[SUM_W]));
    tick();
    check("idle_sum_hold", 32'(sum), 32'(e[SUM_W-1:0]));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    n = '0;
    din = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_ready", 32'(din_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    tick();

    // Back-to-back operands 3,5,7,9 -> 24.
    ops[0] = 4'd3; ops[1] = 4'd5; ops[2] = 4'd7; ops[3] = 4'd9;
    run(4, 0, -1);
    check("t1_sum", 32'(sum), 32'(24));

    // Two idle cycles between operands -> 45.
    ops[0] = 4'd15; ops[1] = 4'd15; ops[2] = 4'd15;
    run(3, 2, -1);
    check("t2_sum", 32'(sum), 32'(45));

    // n == 0 completes immediately with sum 0.
    run(0, 0, -1);

    // Nine times 15 wraps to 7.
    for (int i = 0; i < 9; i++) ops[i] = 4'd15;
    run(9, 0, -1);
    check("t4_sum", 32'(sum), 32'(7));
    check("t4_ovf", 32'(ovf), 32'(OVF_EN));

    // start with n=1 mid-run is ignored.
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd3; ops[3] = 4'd4;
    run(4, 1, 2);
    check("t5_sum", 32'(sum), 32'(10));

    // Asynchronous reset after two of four transfers.
    start = 1'b1;
    n = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1;
      din = 4'd6;
      tick();
    end
    din_valid = 1'b0;
    check("t6_mid_sum", 32'(sum), 32'(12));
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_sum", 32'(sum), 32'(0));
    check("t6_arst_ready", 32'(din_ready), 32'(0));
    check("t6_arst_busy", 32'(busy), 32'(0));
    check("t6_arst_done", 32'(done), 32'(0));
    check("t6_arst_ovf", 32'(ovf), 32'(0));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", 32'(done), 32'(0));
    end
    ops[0] = 4'd1; ops[1] = 4'd2;
    run(2, 0, -1);
    check("t6_sum", 32'(sum), 32'(3));

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
